digit_counter: RTL and testbench



---
 rtl/digit_counter_pkg.sv | 19 +
 rtl/digit_counter_radix_scale.sv | 27 ++
 rtl/digit_counter.sv | 154 +++++++++++++++
 tb/tb_digit_counter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_counter_pkg.sv
// Shared types and legality constants for the digit counter and its radix scaler.
// Optional signed operand support is selected with DIGIT_COUNTER_SIGNED_EN.
package digit_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dc_state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;
  localparam int RADIX_MIN = 2;
  localparam int RADIX_MAX = 16;

  // Headroom above WIDTH so the threshold can exceed 2^WIDTH-1 once without wrapping.
  localparam int THR_EXTRA = 5;

endpackage

// File: rtl/digit_counter_radix_scale.sv
// Combinational threshold scaler: multiplies thr by RADIX and flags a product
// that no longer fits in WIDTH bits. Shared with the radix formatter.
module radix_scale
  import digit_counter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADIX = 10,
  localparam int TW = WIDTH + THR_EXTRA
) (
  input  logic [TW-1:0] thr_i,
  output logic [TW-1:0] prod_o,
  output logic          ovf_o
);

  localparam int PW = TW + 5;

  logic [PW-1:0] full;

  always_comb begin
    full = PW'(thr_i) * PW'(RADIX);
  end

  assign prod_o = full[TW-1:0];
  // Any set bit at or above WIDTH means the product exceeds 2^WIDTH-1.
  assign ovf_o  = |full[PW-1:WIDTH];

endmodule

// File: rtl/digit_counter.sv
// Multi-cycle base-RADIX digit counter with start/done handshake.
// Define DIGIT_COUNTER_SIGNED_EN to treat n as two's complement and expose neg.
module digit_counter
  import digit_counter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADIX = 10,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
`ifdef DIGIT_COUNTER_SIGNED_EN
  ,
  output logic             neg
`endif
);

  localparam int TW = WIDTH + THR_EXTRA;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("digit_counter: WIDTH out of range");
  end
  if (RADIX < RADIX_MIN || RADIX > RADIX_MAX) begin : g_bad_radix
    $error("digit_counter: RADIX out of range");
  end

  dc_state_t        state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [TW-1:0]    thr_q, thr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;
`ifdef DIGIT_COUNTER_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] in_mag;
  logic [TW-1:0]    thr_next;
  logic             thr_ovf;
  logic             reach;

  radix_scale #(
    .WIDTH (WIDTH),
    .RADIX (RADIX)
  ) u_scale (
    .thr_i  (thr_q),
    .prod_o (thr_next),
    .ovf_o  (thr_ovf)
  );

  // Magnitude is taken in WIDTH bits so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
`ifdef DIGIT_COUNTER_SIGNED_EN
    in_mag = n[WIDTH-1] ? (~n + WIDTH'(1)) : n;
`else
    in_mag = n;
`endif
  end

  assign reach = ({{THR_EXTRA{1'b0}}, val_q} >= thr_q);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
`ifdef DIGIT_COUNTER_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          val_d   = in_mag;
          thr_d   = TW'(RADIX);
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef DIGIT_COUNTER_SIGNED_EN
          neg_d   = n[WIDTH-1];
`endif
        end
      end
      RUN: begin
        if (reach && !ovf_q) begin
          cnt_d = cnt_q + CW'(1);
          thr_d = thr_next;
          ovf_d = thr_ovf;
        end else begin
          count_d = cnt_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
`ifdef DIGIT_COUNTER_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
`ifdef DIGIT_COUNTER_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
`ifdef DIGIT_COUNTER_SIGNED_EN
  assign neg   = neg_q;
`endif

endmodule

// File: tb/tb_digit_counter.sv
// Self-checking bench: three digit_counter instances (32b/base10, 8b/base2, 32b/base16)
// compared every cycle against a cycle-numbered behavioural model.
module tb_digit_counter;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st[NI];
  logic [63:0] nv[NI];
  logic        busy_a[NI];
  logic        done_a[NI];
  logic [6:0]  cnt_a[NI];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] n_dec, n_hex;
  logic [7:0]  n_bin;
  logic        start_dec, start_bin, start_hex;
  logic        busy_dec, busy_bin, busy_hex;
  logic        done_dec, done_bin, done_hex;
  logic [5:0]  count_dec, count_hex;
  logic [3:0]  count_bin;
`ifdef DIGIT_COUNTER_SIGNED_EN
  logic        neg_dec, neg_bin, neg_hex;
  logic        neg_a[NI];
  assign neg_a[0] = neg_dec;
  assign neg_a[1] = neg_bin;
  assign neg_a[2] = neg_hex;
`endif

  assign start_dec = st[0];
  assign start_bin = st[1];
  assign start_hex = st[2];
  assign n_dec = nv[0][31:0];
  assign n_bin = nv[1][7:0];
  assign n_hex = nv[2][31:0];
  assign busy_a[0] = busy_dec;
  assign busy_a[1] = busy_bin;
  assign busy_a[2] = busy_hex;
  assign done_a[0] = done_dec;
  assign done_a[1] = done_bin;
  assign done_a[2] = done_hex;
  assign cnt_a[0] = 7'(count_dec);
  assign cnt_a[1] = 7'(count_bin);
  assign cnt_a[2] = 7'(count_hex);

  digit_counter #(.WIDTH(32), .RADIX(10)) u_dec (
    .clk(clk), .rst(rst), .start(start_dec), .n(n_dec),
    .busy(busy_dec), .done(done_dec), .count(count_dec)
`ifdef DIGIT_COUNTER_SIGNED_EN
    , .neg(neg_dec)
`endif
  );

  digit_counter #(.WIDTH(8), .RADIX(2)) u_bin (
    .clk(clk), .rst(rst), .start(start_bin), .n(n_bin),
    .busy(busy_bin), .done(done_bin), .count(count_bin)
`ifdef DIGIT_COUNTER_SIGNED_EN
    , .neg(neg_bin)
`endif
  );

  digit_counter #(.WIDTH(32), .RADIX(16)) u_hex (
    .clk(clk), .rst(rst), .start(start_hex), .n(n_hex),
    .busy(busy_hex), .done(done_hex), .count(count_hex)
`ifdef DIGIT_COUNTER_SIGNED_EN
    , .neg(neg_hex)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int unsigned w_of(input int i);
    return (i == 1) ? 8 : 32;
  endfunction

  function automatic int unsigned r_of(input int i);
    case (i)
      0:       return 10;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  // Number of base-r digits by repeated division.
  function automatic longint unsigned digits(input longint unsigned v, input int unsigned r);
    longint unsigned d = 1;
    while (v >= longint'(r)) begin
      v = v / r;
      d++;
    end
    return d;
  endfunction

  function automatic longint unsigned operand(input int i, input logic [63:0] v);
    longint unsigned w = w_of(i);
    longint unsigned m = v & ((64'd1 << w) - 1);
`ifdef DIGIT_COUNTER_SIGNED_EN
    if (((m >> (w - 1)) & 1) != 0) m = (64'd1 << w) - m;
`endif
    return m;
  endfunction

  function automatic logic is_neg(input int i, input logic [63:0] v);
    return v[w_of(i) - 1];
  endfunction

  // Model: an op accepted in cycle c finishes with done in cycle c+D+1 and frees
  // the block for a new accept in cycle c+D+2.
  longint          cyc = 0;
  longint          acc_at[NI];
  longint          done_at[NI];
  longint          free_at[NI];
  longint unsigned res[NI];
  longint unsigned exp_cnt[NI];
  logic            exp_neg[NI];
  logic            res_neg[NI];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        acc_at[i]  = -1;
        done_at[i] = -1;
        free_at[i] = 0;
        res[i]     = 0;
        exp_cnt[i] = 0;
        exp_neg[i] = 1'b0;
        res_neg[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (cyc >= free_at[i] && st[i]) begin
          res[i]     = digits(operand(i, nv[i]), r_of(i));
          acc_at[i]  = cyc;
          done_at[i] = cyc + longint'(res[i]) + 1;
          free_at[i] = cyc + longint'(res[i]) + 2;
          exp_neg[i] = is_neg(i, nv[i]);
        end
      end
      cyc++;
      for (int i = 0; i < NI; i++)
        if (cyc == done_at[i]) exp_cnt[i] = res[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("busy[%0d]@%0d", i, cyc), busy_a[i],
            longint'(acc_at[i] < cyc && cyc <= done_at[i]));
      check($sformatf("done[%0d]@%0d", i, cyc), done_a[i], longint'(cyc == done_at[i]));
      check($sformatf("count[%0d]@%0d", i, cyc), cnt_a[i], exp_cnt[i]);
`ifdef DIGIT_COUNTER_SIGNED_EN
      check($sformatf("neg[%0d]@%0d", i, cyc), neg_a[i], exp_neg[i]);
`endif
    end
  end

  task automatic wait_idle(input int i);
    int k;
    @(negedge clk);
    for (k = 0; k < 200 && busy_a[i]; k++) @(negedge clk);
    if (busy_a[i]) check("idle_timeout", 1, 0);
  endtask

  // One start pulse; checks literal count and latency (cycles from accept to done).
  task automatic run_one(input int i, input logic [63:0] v, input int exp_c, input int exp_lat,
                         input string name);
    int lat = 0;
    wait_idle(i);
    #1;
    nv[i] = v;
    st[i] = 1'b1;
    @(negedge clk);
    #1;
    st[i] = 1'b0;
    nv[i] = {$urandom, $urandom};
    for (int k = 2; k <= 80; k++) begin
      @(negedge clk);
      if (done_a[i]) begin
        lat = k;
        break;
      end
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_cnt"}, cnt_a[i], exp_c);
  endtask

  initial begin
    int dones;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0;
      nv[i] = '0;
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    check("rst_busy", busy_a[0], 0);
    check("rst_done", done_a[0], 0);
    check("rst_count", cnt_a[0], 0);

`ifdef DIGIT_COUNTER_SIGNED_EN
    run_one(0, 64'hFFFF_CFC7, 5, 6, "dec_m12345");
    check("dec_m12345_neg", neg_a[0], 1);
    run_one(0, 64'h8000_0000, 10, 11, "dec_min");
    check("dec_min_neg", neg_a[0], 1);
    run_one(0, 64'd7, 1, 2, "dec_7");
    check("dec_7_neg", neg_a[0], 0);
    run_one(1, 64'h80, 8, 9, "bin_min");
`else
    run_one(0, 64'd0, 1, 2, "dec_zero");
    run_one(0, 64'd4294967295, 10, 11, "dec_max");
    run_one(0, 64'd1000000000, 10, 11, "dec_1e9");
    run_one(0, 64'd999999999, 9, 10, "dec_999999999");
    run_one(1, 64'hFF, 8, 9, "bin_ff");
    run_one(1, 64'h80, 8, 9, "bin_80");
    run_one(1, 64'h01, 1, 2, "bin_1");
    run_one(2, 64'h0001_0000, 5, 6, "hex_10000");
`endif

    // Start pulsed at t+3 of a 10-digit run must be ignored.
    wait_idle(0);
    #1;
    nv[0] = 64'h7FFF_FFFF;
    st[0] = 1'b1;
    @(negedge clk);
    #1;
    st[0] = 1'b0;
    dones = 0;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (done_a[0]) dones++;
      #1;
      st[0] = (k == 3);
    end
    check("ignore_busy_start_dones", dones, 1);

    // Start held high with a 5-digit operand: done at t+6, t+13, ... t+34.
    wait_idle(0);
    #1;
    nv[0] = 64'd12345;
    st[0] = 1'b1;
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a[0]) begin
        dones++;
        check("held_cnt", cnt_a[0], 5);
      end
    end
    #1 st[0] = 1'b0;
    check("held_dones", dones, 5);

    // Reset at t+5 of a 10-digit run.
    wait_idle(0);
    #1;
    nv[0] = 64'h7FFF_FFFF;
    st[0] = 1'b1;
    @(negedge clk);
    #1;
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", busy_a[0], 0);
    check("midrst_count", cnt_a[0], 0);
    check("midrst_done", done_a[0], 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_a[0]) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_one(0, 64'd999999, 6, 7, "after_rst");

    // Random traffic on all three instances.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        st[i] = (($urandom % 4) == 0);
        nv[i] = {$urandom, $urandom} >> ($urandom % 64);
      end
    end
    #1;
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
